johnson_cnt_param: RTL
======================

Name: johnson_cnt_param

Overview:
Parametrised Johnson (twisted-ring) counter: the next generation of the fixed 4-bit counter. It adds configurable width, up/down direction, synchronous clear and parallel load with legality checking. It also outputs a registered phase index, a wrap pulse and a sticky error flag. It is used as a 2*WIDTH-phase sequencer/timing generator for downstream decode logic.

Parameters:
WIDTH, 4, ring length in bits; legal range 2..16; sequence length is 2*WIDTH states.
PW, $clog2(2*WIDTH), localparam; width of the phase output; not overridable.

Ports:
clk  input  1  rising-edge clock
n_rst  input  1  asynchronous active-low reset
en  input  1  step enable; one step per clock while high
dir  input  1  0 = forward, 1 = reverse; sampled only on enabled steps
clr  input  1  synchronous clear to state 0, clears err
load  input  1  synchronous parallel load of load_val
load_val  input  WIDTH  value to load; must be a legal Johnson state
q  output  WIDTH  counter state, registered
phase  output  PW  index 0..2*WIDTH-1 of current state, registered
wrap  output  1  one-cycle pulse on the sequence wrap boundary, registered
err  output  1  sticky flag: an illegal load_val was presented

Behaviour:
- Reset (n_rst low, asynchronous): q=0, phase=0, wrap=0, err=0. All outputs are registered and update only on the clk rising edge after reset release.
- Legal states: exactly the 2*WIDTH patterns with a contiguous run of ones anchored at bit 0 (0..01..1, including all-zero), or anchored at bit WIDTH-1 (1..10..0, including all-ones).
- Forward step: q_next = {q[WIDTH-2:0], ~q[WIDTH-1]}. For WIDTH=4: 0000,0001,0011,0111,1111,1110,1100,1000,0000.
- Reverse step: q_next = {~q[0], q[WIDTH-1:1]}. This is the exact inverse of the forward step.
- Phase: if q[0]==1 or q==0, phase=popcount(q); otherwise phase=2*WIDTH-popcount(q). phase is computed from q_next and registered with q, so it always matches q in the same cycle.
- Priority per edge: clr > load > en > hold.
  - clr: q=0, phase=0, err=0, wrap=0.
  - load, load_val legal: q=load_val, phase per rule, wrap=0, err unchanged.
  - load, load_val illegal: q=0, phase=0, err=1 (sticky), wrap=0.
  - en: step in direction dir. wrap=1 for the cycle following a forward step from phase 2*WIDTH-1 to 0, or a reverse step from phase 0 to 2*WIDTH-1; otherwise wrap=0.
  - none asserted: q and phase hold, wrap=0.
- Latency: one clock from the control input to q/phase/wrap/err.
- A dir change takes effect on the same edge it is sampled. Reversing mid-sequence simply retraces states; no skip, no dead cycle.
- err clears only via clr or reset. Neither load nor en clears it.
- Reset asserted mid-sequence: immediate return to the reset values, regardless of clk.
- q can never hold an illegal state: the only entry path for one (load) is filtered. No self-correction logic is required beyond this.

Test Plan:
WIDTH=4; n_rst low for 10 ns then high; en=1, dir=0, 9 edges -> q steps 0001,0011,0111,1111,1110,1100,1000,0000,0001; phase 1..7,0,1; wrap=1 only in the cycle q returns to 0000.
From q=0000, dir=1, en=1, 3 edges -> q=1000 (phase 7, wrap=1 in that cycle), then 1100 (6), then 1110 (5).
At q=0111, en=1: toggle dir forward/reverse on alternate edges -> q alternates 1111/0111; phase alternates 4/3; wrap stays 0.
load=1, load_val=1100 -> next cycle q=1100, phase=6, err=0. Then load_val=0101 -> q=0000, phase=0, err=1. err holds through 10 en steps. clr=1 -> err=0, q=0000.
clr, load (load_val=0011) and en all high on one edge -> q=0000, phase=0 (clr wins). Then load+en with load_val=0011 -> q=0011 (load beats step).
Count to q=1110, then pulse n_rst low for 3 ns between edges -> q=0000, phase=0, wrap=0, err=0 immediately; counting resumes from 0001 on the first enabled edge after release.
WIDTH=5 re-run of the forward sweep -> 10-state cycle; phase 0..9; wrap every 10 enabled edges.

Source files
------------

// File: rtl/johnson_cnt_param_if.sv
// Control and status bundle for the parametrised Johnson counter.
// The master drives control and observes state; the slave is the counter itself.
interface johnson_cnt_param_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned PW = $clog2(2 * WIDTH);

  logic             en;
  logic             dir;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [PW-1:0]    phase;
  logic             wrap;
  logic             err;

  modport master (
    output en, dir, clr, load, load_val,
    input  q, phase, wrap, err
  );

  modport slave (
    input  en, dir, clr, load, load_val,
    output q, phase, wrap, err
  );
endinterface

// File: rtl/johnson_cnt_param.sv
// Parametrised up/down Johnson counter with filtered parallel load, registered phase index,
// wrap pulse and sticky illegal-load flag. Sequence length is 2*WIDTH states.
module johnson_cnt_param #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  johnson_cnt_param_if.slave  bus
);
  localparam int unsigned PW = $clog2(2 * WIDTH);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("johnson_cnt_param: WIDTH must be in 2..16");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] fwd, rev;

  // Legal states are a run of ones anchored at bit 0, or its complement.
  function automatic logic is_legal(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] inv;
    inv = ~v;
    return ((v & (v + WIDTH'(1))) == '0) || ((inv & (inv + WIDTH'(1))) == '0);
  endfunction

  function automatic logic [PW-1:0] phase_of(input logic [WIDTH-1:0] v);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones += {31'b0, v[i]};
    end
    if (v[0] || (v == '0)) begin
      return PW'(ones);
    end
    return PW'(2 * WIDTH - ones);
  endfunction

  assign fwd = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
  assign rev = {~q_q[0], q_q[WIDTH-1:1]};

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (bus.clr) begin
      q_d   = '0;
      err_d = 1'b0;
    end else if (bus.load) begin
      if (is_legal(bus.load_val)) begin
        q_d = bus.load_val;
      end else begin
        q_d   = '0;
        err_d = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.dir) begin
        q_d    = rev;
        wrap_d = (q_q == '0);
      end else begin
        q_d    = fwd;
        wrap_d = (fwd == '0);
      end
    end
    phase_d = phase_of(q_d);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q_q     <= '0;
      phase_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.phase = phase_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;
endmodule
